shift_loop_ctrl: RTL and testbench
==================================

# shift_loop_ctrl

Sequencer for the N-stage serial shift register (clk, rst, si, so). It accepts a parallel word over a valid/ready handshake and serialises it LSB-first onto the register's serial input. In parallel it captures the word returning on the serial output after N cycles of delay. It presents the deserialised result with a mismatch flag, so the shift register can run as a self-checking delay line or loopback path.

## Interface
Parameters:
- N, 4, depth of the external shift register (serial delay in cycles), N >= 1
- W, 8, word width, W >= 1

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset; the same net also resets the external shift register
- in_valid  input  1  in_data is valid
- in_data  input  W  word to send
- in_ready  output  1  controller can accept a word (high only in IDLE)
- sr_si  output  1  drives external shift register si
- sr_so  input  1  from external shift register so
- out_valid  output  1  out_data/mismatch valid
- out_data  output  W  captured word
- mismatch  output  1  out_data != word sent
- out_ready  input  1  consumer accepts result
- busy  output  1  state != IDLE

## Operation
- States: IDLE, RUN, HOLD. Internal registers: tx_word[W], tx_sh[W], rx_sh[W], cnt (width clog2(W+N)).
- Reset (async, any state): state=IDLE, cnt=0, tx_word/tx_sh/rx_sh=0.
  - Outputs during reset: in_ready=1, sr_si=0, out_valid=0, out_data=0, mismatch=0, busy=0.
- IDLE:
  - in_ready=1, sr_si=0.
  - On an edge with in_valid=1: tx_word=in_data, tx_sh=in_data, cnt=0, go to RUN.
- RUN:
  - sr_si = tx_sh[0] when cnt < W, else 0.
  - Each edge with cnt < W: tx_sh shifts right by one (0 fills the MSB).
  - Each edge with cnt >= N: rx_sh = {sr_so, rx_sh[W-1:1]}.
  - cnt increments each edge.
  - On the edge where cnt == W+N-1: perform that edge's capture, go to HOLD, cnt=0.
  - RUN therefore lasts exactly W+N cycles.
- HOLD:
  - out_valid=1, out_data=rx_sh, mismatch=(rx_sh != tx_word).
  - Outputs stay stable until an edge with out_ready=1, which moves the state to IDLE.
- out_data and mismatch read 0 whenever out_valid=0.
- sr_si is a combinational function of state, cnt and tx_sh only (no path from inputs), so it is glitch-free relative to clk.
- in_valid arriving outside IDLE is ignored. The producer must hold it until in_ready.
- The capture window (cnt N .. W+N-1) overlaps the drive window (cnt 0 .. W-1) when W > N. No extra buffering is needed because rx_sh and tx_sh are independent.

## Timing
- Path latency: the bit driven on sr_si in RUN cycle k is sampled from sr_so at the edge ending RUN cycle k+N. This holds because the external register shifts every clock.
- Accept edge to out_valid: 1 + W + N - 1 = W+N edges. out_valid rises on the edge that ends RUN cycle W+N-1.
- Minimum period per word: W+N+2 cycles (RUN W+N, HOLD >= 1, IDLE >= 1).
- in_ready=0 from the accept edge until the edge after the HOLD handshake.
- Simultaneous out_ready and a new in_valid during HOLD: only HOLD to IDLE happens. The new word is accepted at the next edge.
- Reset mid-RUN or mid-HOLD: all of the above return to reset values immediately, and any in-flight word is discarded. The external register is cleared by the same rst, so no stale bits appear in the next word.
- After the drive window, sr_si=0. Trailing register contents are zeros when RUN ends.

## Test plan
(N=4, W=8)
- Basic loopback: send 0xA5 with out_ready=1.
  - sr_si sequence 1,0,1,0,0,1,0,1 in RUN cycles 0-7, then 0 for cycles 8-11.
  - out_valid rises 12 edges after accept, with out_data=0xA5 and mismatch=0.
- Stuck fault: force sr_so=0 and send 0xFF -> out_data=0x00, mismatch=1.
  - Force sr_so=1 and send 0x00 -> out_data=0xFF, mismatch=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD.
  - out_valid, out_data=0x3C and mismatch stay stable.
  - in_ready=0 and busy=1 throughout.
  - A single cycle of out_ready returns the block to IDLE.
- Back-to-back: in_valid held high with 0x01 then 0x80, out_ready=1.
  - Results 0x01 then 0x80, both mismatch=0.
  - Accept edges exactly 14 cycles apart.
- Reset mid-RUN: assert rst at RUN cycle 6 of word 0x5A.
  - All outputs go to reset values at once, with no out_valid pulse.
  - A following word 0xC3 returns out_data=0xC3, mismatch=0.
- Ignored input: pulse in_valid during RUN -> no state change, and the result of the in-flight word is unaffected.

Source files
------------

// File: rtl/shift_loop_ctrl.sv
// shift_loop_ctrl: drives a parallel word LSB-first into an external N-stage
// serial shift register and captures the word coming back out N cycles
// later. The result is presented with a flag that says whether the returned
// word differs from the word sent, so the register can be used as a
// self-checking delay line or loopback path.
//
// Handshakes: a transfer on either side happens on a rising clk edge where
// valid and ready are both high. The producer holds in_valid/in_data until
// in_ready. out_valid/out_data/mismatch stay stable until out_ready is seen.
module shift_loop_ctrl #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         sr_si,
  input  logic         sr_so,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         mismatch,
  input  logic         out_ready,
  output logic         busy
);

  // Counter covers 0 .. W+N-1, so W, N and W+N-1 all fit in CW bits.
  localparam int CW = $clog2(W + N);
  localparam logic [CW-1:0] W_C    = CW'(W);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(W + N - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   tx_word_q;
  logic [W-1:0]   tx_sh_q;
  logic [W-1:0]   rx_sh_q;
  logic [W-1:0]   rx_sh_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic           mismatch_q;
  logic           busy_q;

  // Next receive shift value: returning bit enters at the MSB so that after
  // W captures the first bit sent sits at bit 0.
  always_comb begin
    rx_sh_d        = rx_sh_q >> 1;
    rx_sh_d[W-1]   = sr_so;
  end

  // Serial drive depends only on registered state, so it cannot glitch on
  // input changes; zeros follow the word to flush the external register.
  assign sr_si = (state_q == S_RUN) && (cnt_q < W_C) ? tx_sh_q[0] : 1'b0;

  // Sequencer: IDLE accepts, RUN drives/captures for W+N cycles, HOLD
  // presents the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_word_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mismatch_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            tx_word_q  <= in_data;
            tx_sh_q    <= in_data;
            cnt_q      <= '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        S_RUN: begin
          if (cnt_q < W_C) begin
            tx_sh_q <= tx_sh_q >> 1;
          end
          if (cnt_q >= N_C) begin
            rx_sh_q <= rx_sh_d;
          end
          if (cnt_q == LAST_C) begin
            // Final capture happens on this same edge, so the result is
            // taken from the next-value path rather than rx_sh_q.
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= rx_sh_d;
            mismatch_q  <= (rx_sh_d != tx_word_q);
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          mismatch_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mismatch  = mismatch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_loop_ctrl.sv
// Bench for shift_loop_ctrl with N=4, W=8. Includes a model of the external
// shift register (reset by the same rst) with a stuck-at override on so.
module tb_shift_loop_ctrl;

  localparam int N = 4;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         in_ready;
  logic         sr_si;
  logic         sr_so;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         mismatch;
  logic         out_ready = 1'b0;
  logic         busy;

  logic         force_en  = 1'b0;
  logic         force_val = 1'b0;
  logic [N-1:0] sr_q;

  // External N-stage shift register, shifting every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= {sr_q[N-2:0], sr_si};
  end
  assign sr_so = force_en ? force_val : sr_q[N-1];

  shift_loop_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sr_si     (sr_si),
    .sr_so     (sr_so),
    .out_valid (out_valid),
    .out_data  (out_data),
    .mismatch  (mismatch),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         force_en;
    logic         force_val;
    int           hold;      // extra HOLD cycles with out_ready=0
    int           pulse;     // RUN cycle with a stray in_valid, -1 none
    int           abort_at;  // RUN cycle where rst is asserted, -1 none
    logic [W-1:0] exp_data;
    logic         exp_mis;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_sr_si"},     sr_si, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_mismatch"},  mismatch, 0);
    chk({tag, "_busy"},      busy, 0);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic send_vec(input vec_t v);
    logic exp_bit;
    force_en  = v.force_en;
    force_val = v.force_val;
    in_valid  = 1'b1;
    in_data   = v.data;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid  = 1'b0;
    for (int k = 0; k < W + N; k++) begin
      if (k == v.abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        chk("abort_no_valid", out_valid, 0);
        @(negedge clk);
        chk("abort_still_idle", busy, 0);
        rst      = 1'b0;
        force_en = 1'b0;
        return;
      end
      exp_bit = (k < W) ? v.data[k] : 1'b0;
      chk($sformatf("sr_si_k%0d", k), sr_si, exp_bit);
      chk("run_busy",      busy, 1);
      chk("run_in_ready",  in_ready, 0);
      chk("run_out_valid", out_valid, 0);
      in_valid = (k == v.pulse);
      in_data  = (k == v.pulse) ? ~v.data : v.data;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int h = 0; h <= v.hold; h++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_data",  out_data, v.exp_data);
      chk("hold_mismatch",  mismatch, v.exp_mis);
      chk("hold_in_ready",  in_ready, 0);
      chk("hold_busy",      busy, 1);
      out_ready = (h == v.hold);
      @(negedge clk);
    end
    out_ready = 1'b0;
    force_en  = 1'b0;
    chk("done_out_valid", out_valid, 0);
    chk("done_out_data",  out_data, 0);
    chk("done_mismatch",  mismatch, 0);
    chk("done_in_ready",  in_ready, 1);
    chk("done_busy",      busy, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int n_acc;
    int n_res;
    int acc_cyc[2];
    int cyc;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 0, -1, -1, 8'hA5, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 0, -1, -1, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0, -1, -1, 8'hFF, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 5, -1, -1, 8'h3C, 1'b0};
    vecs[4] = '{8'h66, 1'b0, 1'b0, 0,  3, -1, 8'h66, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 0, -1,  6, 8'h00, 1'b0};
    vecs[6] = '{8'hC3, 1'b0, 1'b0, 0, -1, -1, 8'hC3, 1'b0};

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < NV; i++) begin
      wait_idle();
      send_vec(vecs[i]);
    end

    // Back-to-back: in_valid held high across two words.
    wait_idle();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    cyc = 0;
    while (n_res < 2 && cyc < 80) begin
      in_valid = (n_acc < 2);
      in_data  = (n_acc == 0) ? 8'h01 : 8'h80;
      if (out_valid) begin
        n_res++;
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected", out_data, 0);
        end else begin
          chk("b2b_data", out_data, exp_q.pop_front());
          chk("b2b_mismatch", mismatch, 0);
        end
      end
      if (in_valid && in_ready && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", n_res, 2);
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 14);
    chk("b2b_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("final_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
